// File: rtl/ospi_flash_array_if.sv
// Command, program-data and read-data bundle between a host and the flash array model.
interface ospi_flash_array_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 10
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        cmd_len;
    logic              wdata_valid;
    logic [DATA_W-1:0] wdata;
    logic              wdata_ready;
    logic              rdata_valid;
    logic [DATA_W-1:0] rdata;
    logic [2:0]        status;
    logic              hold_n;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_len, wdata_valid, wdata, hold_n,
        input  cmd_ready, wdata_ready, rdata_valid, rdata, status
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len, wdata_valid, wdata, hold_n,
        output cmd_ready, wdata_ready, rdata_valid, rdata, status
    );
endinterface

// File: rtl/ospi_flash_array.sv
// Cycle-accurate OSPI NOR flash array: WEL/err status, page-buffered AND program,
// multi-cycle sector erase, burst read with hold stalling.
module ospi_flash_array #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned PAGE_WORDS   = 16,
    parameter int unsigned SECTOR_WORDS = 64,
    parameter int unsigned PROG_CYCLES  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    ospi_flash_array_if.slave bus
);
    localparam int unsigned DEPTH   = 2 ** ADDR_W;
    localparam int unsigned PAGE_AW = $clog2(PAGE_WORDS);
    localparam int unsigned CNT_W   = 16;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_WREN = 3'd1;
    localparam logic [2:0] OP_WRDI = 3'd2;
    localparam logic [2:0] OP_READ = 3'd3;
    localparam logic [2:0] OP_PGM  = 3'd4;
    localparam logic [2:0] OP_ERS  = 3'd5;
    localparam logic [2:0] OP_RDSR = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_PGM_LOAD, S_PGM_COMMIT, S_PGM_WAIT, S_ERASE
    } state_t;

    state_t             state_q, state_d;
    logic               wel_q, wel_d, err_q, err_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [PAGE_AW-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               rdata_valid_q, rdata_valid_d;

    // Array is stored inverted so a zero power-up state reads as erased (all ones).
    logic [DATA_W-1:0]     mem_n [DEPTH];
    logic [DATA_W-1:0]     pbuf [PAGE_WORDS];
    logic [PAGE_WORDS-1:0] pmask;

    logic              busy_c, cmd_ready_c, cmd_fire_c, wdata_fire_c, buf_clear_c, mem_we_c;
    logic [ADDR_W-1:0] mem_waddr_c, commit_addr_c, rd_addr_c;
    logic [DATA_W-1:0] mem_wdata_c, rd_word_c;

    assign busy_c        = (state_q == S_PGM_COMMIT) || (state_q == S_PGM_WAIT) || (state_q == S_ERASE);
    assign cmd_ready_c   = !((state_q == S_READ) || (state_q == S_PGM_LOAD));
    assign cmd_fire_c    = bus.cmd_valid && cmd_ready_c;
    assign wdata_fire_c  = (state_q == S_PGM_LOAD) && bus.wdata_valid && bus.hold_n;
    assign commit_addr_c = addr_q | ADDR_W'(idx_q);
    assign rd_addr_c     = (state_q == S_READ) ? addr_q : bus.cmd_addr;
    assign rd_word_c     = ~mem_n[rd_addr_c];

    assign bus.cmd_ready   = cmd_ready_c;
    assign bus.wdata_ready = (state_q == S_PGM_LOAD) && bus.hold_n;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.rdata       = rdata_q;
    assign bus.status      = {err_q, wel_q, busy_c};

    // Control state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            wel_q         <= 1'b0;
            err_q         <= 1'b0;
            addr_q        <= '0;
            idx_q         <= '0;
            cnt_q         <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wel_q         <= wel_d;
            err_q         <= err_d;
            addr_q        <= addr_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    // Next-state, command decode and array write strobes.
    always_comb begin
        state_d       = state_q;
        wel_d         = wel_q;
        err_d         = err_q;
        addr_d        = addr_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        buf_clear_c   = 1'b0;
        mem_we_c      = 1'b0;
        mem_waddr_c   = addr_q;
        mem_wdata_c   = '1;

        if (cmd_fire_c && busy_c) begin
            if (bus.cmd_op == OP_RDSR) begin
                rdata_d       = DATA_W'({err_q, wel_q, 1'b1});
                rdata_valid_d = 1'b1;
            end else if (bus.cmd_op != OP_NOP) begin
                err_d = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (cmd_fire_c) begin
                    case (bus.cmd_op)
                        OP_NOP: ;
                        OP_WREN: begin
                            wel_d = 1'b1;
                            err_d = 1'b0;
                        end
                        OP_WRDI: wel_d = 1'b0;
                        OP_RDSR: begin
                            rdata_d       = DATA_W'({err_q, wel_q, 1'b0});
                            rdata_valid_d = 1'b1;
                        end
                        OP_READ: begin
                            if (bus.hold_n) begin
                                rdata_d       = rd_word_c;
                                rdata_valid_d = 1'b1;
                                addr_d        = bus.cmd_addr + ADDR_W'(1);
                                cnt_d         = CNT_W'(bus.cmd_len);
                                if (bus.cmd_len != 8'd0) state_d = S_READ;
                            end else begin
                                addr_d  = bus.cmd_addr;
                                cnt_d   = CNT_W'(bus.cmd_len) + CNT_W'(1);
                                state_d = S_READ;
                            end
                        end
                        OP_PGM: begin
                            if (!wel_q) begin
                                err_d = 1'b1;
                            end else begin
                                buf_clear_c = 1'b1;
                                addr_d      = bus.cmd_addr & ~ADDR_W'(PAGE_WORDS - 1);
                                idx_d       = bus.cmd_addr[PAGE_AW-1:0];
                                cnt_d       = CNT_W'(bus.cmd_len) + CNT_W'(1);
                                state_d     = S_PGM_LOAD;
                            end
                        end
                        OP_ERS: begin
                            if (!wel_q) begin
                                err_d = 1'b1;
                            end else begin
                                addr_d  = bus.cmd_addr & ~ADDR_W'(SECTOR_WORDS - 1);
                                cnt_d   = CNT_W'(SECTOR_WORDS);
                                state_d = S_ERASE;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_READ: begin
                if (bus.hold_n) begin
                    rdata_d       = rd_word_c;
                    rdata_valid_d = 1'b1;
                    addr_d        = addr_q + ADDR_W'(1);
                    cnt_d         = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
                end
            end
            S_PGM_LOAD: begin
                if (wdata_fire_c) begin
                    idx_d = idx_q + PAGE_AW'(1);
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        idx_d   = '0;
                        cnt_d   = CNT_W'(PAGE_WORDS);
                        state_d = S_PGM_COMMIT;
                    end
                end
            end
            S_PGM_COMMIT: begin
                mem_waddr_c = commit_addr_c;
                mem_wdata_c = ~mem_n[commit_addr_c] & pbuf[idx_q];
                mem_we_c    = pmask[idx_q];
                idx_d       = idx_q + PAGE_AW'(1);
                cnt_d       = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = CNT_W'(PROG_CYCLES);
                    state_d = S_PGM_WAIT;
                end
            end
            S_PGM_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    wel_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_ERASE: begin
                mem_we_c = 1'b1;
                addr_d   = addr_q + ADDR_W'(1);
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    wel_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Page buffer: cleared at program start, filled by the data stream.
    always_ff @(posedge clk) begin
        if (buf_clear_c) begin
            pmask <= '0;
            for (int i = 0; i < int'(PAGE_WORDS); i++) pbuf[i] <= '1;
        end else if (wdata_fire_c) begin
            pbuf[idx_q]  <= bus.wdata;
            pmask[idx_q] <= 1'b1;
        end
    end

    // Flash array (not reset; committed words survive reset).
    always_ff @(posedge clk) begin
        if (mem_we_c) mem_n[mem_waddr_c] <= ~mem_wdata_c;
    end
endmodule

// File: tb/tb_ospi_flash_array.sv
// Self-checking bench for ospi_flash_array against a word-level reference model.
module tb_ospi_flash_array;
    localparam logic [2:0] OP_WREN = 3'd1;
    localparam logic [2:0] OP_WRDI = 3'd2;
    localparam logic [2:0] OP_READ = 3'd3;
    localparam logic [2:0] OP_PGM  = 3'd4;
    localparam logic [2:0] OP_ERS  = 3'd5;
    localparam logic [2:0] OP_RDSR = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    logic [7:0] ref_mem [1024];
    logic       ref_wel;
    logic       ref_err;
    logic [7:0] wq [$];

    ospi_flash_array_if #(.DATA_W(8), .ADDR_W(10)) bus ();

    ospi_flash_array #(
        .DATA_W(8), .ADDR_W(10), .PAGE_WORDS(16), .SECTOR_WORDS(64), .PROG_CYCLES(8)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check(tag, 32'(bus.status), 32'({ref_err, ref_wel, 1'b0}));
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_cmd(input logic [2:0] op, input logic [9:0] a, input logic [7:0] l);
        int t = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        while (!bus.cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wren();
        send_cmd(OP_WREN, 10'd0, 8'd0);
        ref_wel = 1'b1;
        ref_err = 1'b0;
    endtask

    // Burst read; hold_n is low during cycles [hold_at, hold_at+hold_len) counted from acceptance.
    task automatic do_read(input logic [9:0] a, input logic [7:0] l, input int hold_at,
                           input int hold_len, input string tag);
        int         n = int'(l) + 1;
        int         issued = 0;
        logic       prev_hold = 1'b1;
        logic       exp_pulse;
        logic [9:0] ra;
        send_cmd(OP_READ, a, l);
        for (int c = 0; c < n + hold_len + 3; c++) begin
            exp_pulse = prev_hold && (issued < n);
            check({tag, "_valid"}, 32'(bus.rdata_valid), 32'(exp_pulse));
            if (exp_pulse) begin
                ra = a + 10'(issued);
                check({tag, "_data"}, 32'(bus.rdata), 32'(ref_mem[ra]));
                issued++;
            end
            bus.hold_n = !(c >= hold_at && c < hold_at + hold_len);
            prev_hold  = bus.hold_n;
            @(negedge clk);
        end
        bus.hold_n = 1'b1;
        check({tag, "_done_ready"}, 32'(bus.cmd_ready), 32'd1);
    endtask

    // Program n words from wq starting at a; random hold_n stalls when rand_hold is set.
    task automatic do_program(input logic [9:0] a, input int n, input bit rand_hold, input string tag);
        logic [7:0] pb [16];
        bit         pm [16];
        int         idx, i, guard, busy_cnt;
        logic [9:0] base;
        bit         ok = ref_wel;
        send_cmd(OP_PGM, a, 8'(n - 1));
        if (!ok) begin
            ref_err = 1'b1;
            check_status({tag, "_nowel_status"});
            return;
        end
        for (int k = 0; k < 16; k++) begin
            pb[k] = 8'hFF;
            pm[k] = 1'b0;
        end
        base = a & 10'h3F0;
        idx  = int'(a[3:0]);
        i = 0;
        guard = 0;
        while (i < n && guard < 2000) begin
            bus.hold_n      = rand_hold ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.wdata_valid = 1'b1;
            bus.wdata       = wq[i];
            #1;
            check({tag, "_wready"}, 32'(bus.wdata_ready), 32'(bus.hold_n));
            @(posedge clk);
            if (bus.hold_n) begin
                pb[idx] = wq[i];
                pm[idx] = 1'b1;
                idx = (idx + 1) % 16;
                i++;
            end
            @(negedge clk);
            guard++;
        end
        bus.wdata_valid = 1'b0;
        bus.hold_n      = 1'b1;
        check({tag, "_words"}, 32'(i), 32'(n));
        busy_cnt = 0;
        while (bus.status[0] && busy_cnt < 200) begin
            busy_cnt++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd24);
        for (int k = 0; k < 16; k++)
            if (pm[k]) ref_mem[base + 10'(k)] = ref_mem[base + 10'(k)] & pb[k];
        ref_wel = 1'b0;
        check_status({tag, "_status"});
    endtask

    // Sector erase; optional RDSR, a dropped WREN, or a reset abort at given cycles.
    task automatic do_erase(input logic [9:0] a, input int rdsr_at, input int drop_at, input int abort_at);
        logic [9:0] base;
        int         c = 0;
        logic [2:0] pend = 3'd0;
        bit         ok = ref_wel;
        send_cmd(OP_ERS, a, 8'd0);
        if (!ok) begin
            ref_err = 1'b1;
            check_status("erase_nowel_status");
            return;
        end
        base = a & 10'h3C0;
        while (bus.status[0] && c < 200) begin
            if (pend == OP_RDSR)
                check("erase_rdsr", 32'({bus.rdata_valid, bus.rdata}),
                      32'({1'b1, 5'b0, ref_err, ref_wel, 1'b1}));
            else if (pend == OP_WREN)
                ref_err = 1'b1;
            pend = 3'd0;
            bus.cmd_valid = 1'b0;
            if (c == abort_at) break;
            if (c == rdsr_at) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = OP_RDSR;
                pend          = OP_RDSR;
            end
            if (c == drop_at) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = OP_WREN;
                pend          = OP_WREN;
            end
            @(negedge clk);
            c++;
        end
        if (c == abort_at) begin
            for (int k = 0; k < c; k++) ref_mem[base + 10'(k)] = 8'hFF;
            reset_n = 1'b0;
            #2;
            ref_wel = 1'b0;
            ref_err = 1'b0;
            check_status("abort_status");
            check("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
            check("abort_rdata_valid", 32'(bus.rdata_valid), 32'd0);
            @(negedge clk);
            reset_n = 1'b1;
            @(negedge clk);
        end else begin
            check("erase_busy_cycles", 32'(c), 32'd64);
            for (int k = 0; k < 64; k++) ref_mem[base + 10'(k)] = 8'hFF;
            ref_wel = 1'b0;
            check_status("erase_status");
        end
    endtask

    initial begin
        logic [9:0] ra;
        int         rn;
        checks = 0;
        errors = 0;
        for (int k = 0; k < 1024; k++) ref_mem[k] = 8'hFF;
        ref_wel = 1'b0;
        ref_err = 1'b0;
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = 3'd0;
        bus.cmd_addr    = '0;
        bus.cmd_len     = '0;
        bus.wdata_valid = 1'b0;
        bus.wdata       = '0;
        bus.hold_n      = 1'b1;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_status("reset_status");
        check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("reset_wdata_ready", 32'(bus.wdata_ready), 32'd0);
        check("reset_rdata_valid", 32'(bus.rdata_valid), 32'd0);
        check("reset_rdata", 32'(bus.rdata), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        send_cmd(OP_RDSR, 10'd0, 8'd0);
        check("rdsr_idle", 32'({bus.rdata_valid, bus.rdata}), 32'h100);

        do_read(10'h000, 8'd3, 100, 0, "rd_blank");
        check_status("rd_blank_status");

        wq = '{8'hA5, 8'h3C, 8'h0F, 8'hF0};
        do_program(10'h00E, 4, 1'b0, "pgm_nowel");
        do_read(10'h000, 8'd15, 100, 0, "rd_unchanged");
        wren();
        check("wren_status", 32'(bus.status), 32'b010);

        do_program(10'h00E, 4, 1'b0, "pgm_wrap");
        do_read(10'h000, 8'd15, 100, 0, "rd_wrap");

        wren();
        wq = '{8'h5A};
        do_program(10'h00E, 1, 1'b0, "pgm_and");
        do_read(10'h00E, 8'd0, 100, 0, "rd_and");

        wren();
        wq = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        do_program(10'h040, 4, 1'b0, "pgm_040");
        wren();
        do_erase(10'h025, 20, -1, -1);
        do_read(10'h000, 8'd63, 100, 0, "rd_erased");
        do_read(10'h040, 8'd3, 100, 0, "rd_untouched");

        do_read(10'h3FE, 8'd3, 1, 2, "rd_hold_wrap");

        send_cmd(OP_RSVD, 10'd0, 8'd0);
        ref_err = 1'b1;
        check_status("op7_status");
        wren();
        send_cmd(OP_WRDI, 10'd0, 8'd0);
        ref_wel = 1'b0;
        check_status("wrdi_status");

        wren();
        do_erase(10'h100, -1, 5, -1);

        wren();
        wq.delete();
        for (int k = 0; k < 32; k++) wq.push_back(8'($urandom));
        do_program(10'h080, 16, 1'b1, "pgm_080");
        wren();
        for (int k = 0; k < 16; k++) wq[k] = wq[k + 16];
        do_program(10'h090, 16, 1'b0, "pgm_090");
        wren();
        do_erase(10'h0A3, -1, -1, 10);
        check("post_abort_ready", 32'(bus.cmd_ready), 32'd1);
        do_read(10'h080, 8'd31, 100, 0, "rd_abort");
        check_status("post_abort_status");

        for (int it = 0; it < 6; it++) begin
            ra = 10'($urandom_range(0, 1023));
            rn = $urandom_range(1, 24);
            wq.delete();
            for (int k = 0; k < rn; k++) wq.push_back(8'($urandom));
            wren();
            do_program(ra, rn, 1'b1, "rnd_pgm");
            do_read(ra & 10'h3F0, 8'd15, $urandom_range(0, 10), $urandom_range(0, 3), "rnd_rd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
